// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment scan controller:
// the hex glyph table, the glyph/polarity decode function and a
// width helper for the digit index.
package seg7_pkg;

  // Active-high glyphs {g,f,e,d,c,b,a}; entry n is the pattern for nibble n.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Build {dp,g..a} for a nibble, inverted for active-low segment drive.
  function automatic logic [7:0] seg7_glyph(input logic [3:0] nibble,
                                            input logic       dp,
                                            input logic       active_low);
    logic [7:0] raw;
    raw = {dp, GLYPH_TABLE[nibble]};
    return active_low ? ~raw : raw;
  endfunction

  // Width of a counter able to address n digits (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder with decimal point and polarity.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       active_low,
  output logic [7:0] seg
);

  // Pure table lookup; polarity is applied inside the helper.
  always_comb begin
    seg = seg7_glyph(nibble, dp, active_low);
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment display scanner. A free-running prescaler splits
// time into digit slots; each slot's upper four prescaler bits form a PWM
// phase for brightness. New data is staged in shadow registers and only
// becomes visible at the frame wrap so a scan never shows mixed data.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int DIV_W          = 15,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cs,
  input  logic [4*DIGITS-1:0]   i_data,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic [DIGITS-1:0]     i_blank,
  input  logic                  i_lzb,
  input  logic [3:0]            i_bright,
  output logic [7:0]            o_seg,
  output logic [DIGITS-1:0]     o_sel,
  output logic                  o_frame
);

  localparam int                IDX_W    = idx_width(DIGITS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [7:0]        SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] SEL_OFF  = SEL_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [DIV_W-1:0]    presc_r;
  logic [IDX_W-1:0]    idx_r;
  logic [4*DIGITS-1:0] shadow_data_r;
  logic [DIGITS-1:0]   shadow_dp_r;
  logic [DIGITS-1:0]   shadow_blank_r;
  logic [4*DIGITS-1:0] act_data_r;
  logic [DIGITS-1:0]   act_dp_r;
  logic [DIGITS-1:0]   act_blank_r;
  logic [7:0]          seg_r;
  logic [DIGITS-1:0]   sel_r;
  logic                frame_r;

  logic                tick_s;
  logic                wrap_s;
  logic [3:0]          phase_s;
  logic [3:0]          nib_s;
  logic                dp_s;
  logic                blank_s;
  logic [IDX_W-1:0]    msnz_s;
  logic                lz_blank_s;
  logic                lit_s;
  logic [7:0]          glyph_s;
  logic [DIGITS-1:0]   sel_hot_s;
  logic [DIGITS-1:0]   sel_on_s;

  assign tick_s  = &presc_r;
  assign wrap_s  = tick_s && (idx_r == LAST_IDX);
  assign phase_s = presc_r[DIV_W-1 -: 4];

  // Prescaler and digit index: index steps once per slot, wrapping per frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_r <= {DIV_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
    end else begin
      presc_r <= presc_r + DIV_W'(1);
      if (tick_s) begin
        if (idx_r == LAST_IDX) begin
          idx_r <= {IDX_W{1'b0}};
        end else begin
          idx_r <= idx_r + IDX_W'(1);
        end
      end
    end
  end

  // Shadow capture on every write strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_data_r  <= {(4*DIGITS){1'b0}};
      shadow_dp_r    <= {DIGITS{1'b0}};
      shadow_blank_r <= {DIGITS{1'b0}};
    end else if (cs) begin
      shadow_data_r  <= i_data;
      shadow_dp_r    <= i_dp;
      shadow_blank_r <= i_blank;
    end
  end

  // Active copy only at the frame wrap; a write on that very edge bypasses the shadow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_data_r  <= {(4*DIGITS){1'b0}};
      act_dp_r    <= {DIGITS{1'b0}};
      act_blank_r <= {DIGITS{1'b0}};
    end else if (wrap_s) begin
      if (cs) begin
        act_data_r  <= i_data;
        act_dp_r    <= i_dp;
        act_blank_r <= i_blank;
      end else begin
        act_data_r  <= shadow_data_r;
        act_dp_r    <= shadow_dp_r;
        act_blank_r <= shadow_blank_r;
      end
    end
  end

  // Select the current digit's nibble and flags from the active registers.
  always_comb begin
    nib_s   = act_data_r[{idx_r, 2'b00} +: 4];
    dp_s    = act_dp_r[idx_r];
    blank_s = act_blank_r[idx_r];
  end

  // Locate the most significant nonzero nibble; digit 0 when all are zero.
  always_comb begin
    msnz_s = {IDX_W{1'b0}};
    for (int k = 0; k < DIGITS; k++) begin
      msnz_s = (act_data_r[4*k +: 4] != 4'h0) ? IDX_W'(k) : msnz_s;
    end
  end

  // A slot is lit inside its PWM window unless forced or leading-zero blanked.
  always_comb begin
    lz_blank_s = i_lzb && (idx_r > msnz_s);
    lit_s      = (phase_s <= i_bright) && !blank_s && !lz_blank_s;
    sel_hot_s  = DIGITS'(1'b1) << idx_r;
    sel_on_s   = SEL_ACTIVE_LOW ? ~sel_hot_s : sel_hot_s;
  end

  seg7_decode u_decode (
    .nibble     (nib_s),
    .dp         (dp_s),
    .active_low (SEG_ACTIVE_LOW),
    .seg        (glyph_s)
  );

  // Registered outputs: glitch-free one-hot select and a one-cycle frame pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_r   <= SEG_OFF;
      sel_r   <= SEL_OFF;
      frame_r <= 1'b0;
    end else begin
      frame_r <= wrap_s;
      if (lit_s) begin
        seg_r <= glyph_s;
        sel_r <= sel_on_s;
      end else begin
        seg_r <= SEG_OFF;
        sel_r <= SEL_OFF;
      end
    end
  end

  assign o_seg   = seg_r;
  assign o_sel   = sel_r;
  assign o_frame = frame_r;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl (8 digits, 16-clock slots, active-low drive).
// A time-based reference model predicts every output cycle; table vectors
// and short sequences pin down the documented examples and corner cases.
module tb_seg7_scan_ctrl;

  localparam int DIGITS = 8;
  localparam int SLOT   = 16;
  localparam int FRAME  = DIGITS * SLOT;

  logic        clk      = 1'b0;
  logic        reset_n  = 1'b0;
  logic        cs       = 1'b0;
  logic [31:0] i_data   = 32'h0;
  logic [7:0]  i_dp     = 8'h0;
  logic [7:0]  i_blank  = 8'h0;
  logic        i_lzb    = 1'b0;
  logic [3:0]  i_bright = 4'd15;
  logic [7:0]  o_seg;
  logic [7:0]  o_sel;
  logic        o_frame;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .DIGITS(DIGITS), .DIV_W(4), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .i_data(i_data), .i_dp(i_dp),
    .i_blank(i_blank), .i_lzb(i_lzb), .i_bright(i_bright),
    .o_seg(o_seg), .o_sel(o_sel), .o_frame(o_frame)
  );

  // ---------------- reference model ----------------
  logic [7:0] glyph [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  int   pos = 0;
  int   sh_nib  [DIGITS];
  bit   sh_dp   [DIGITS];
  bit   sh_blank[DIGITS];
  int   act_nib [DIGITS];
  bit   act_dp  [DIGITS];
  bit   act_blank[DIGITS];
  logic [7:0] exp_sel   = 8'hFF;
  logic [7:0] exp_seg   = 8'hFF;
  logic       exp_frame = 1'b0;

  function automatic logic [15:0] expected_out(input int slot, input int ph);
    int top;
    bit lit;
    logic [7:0] s;
    top = 0;
    for (int d = 0; d < DIGITS; d++) if (act_nib[d] != 0) top = d;
    lit = !act_blank[slot] && !(i_lzb && slot > top) && (ph <= int'(i_bright));
    if (!lit) return 16'hFFFF;
    s = glyph[act_nib[slot]] | (act_dp[slot] ? 8'h80 : 8'h00);
    return {~(8'h01 << slot), ~s};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos       <= 0;
      exp_sel   <= 8'hFF;
      exp_seg   <= 8'hFF;
      exp_frame <= 1'b0;
      for (int d = 0; d < DIGITS; d++) begin
        sh_nib[d] <= 0; sh_dp[d] <= 1'b0; sh_blank[d] <= 1'b0;
        act_nib[d] <= 0; act_dp[d] <= 1'b0; act_blank[d] <= 1'b0;
      end
    end else begin
      {exp_sel, exp_seg} <= expected_out(pos / SLOT, pos % SLOT);
      exp_frame <= (pos == FRAME - 1);
      for (int d = 0; d < DIGITS; d++) begin
        if (pos == FRAME - 1) begin
          act_nib[d]   <= cs ? int'(i_data[4*d +: 4]) : sh_nib[d];
          act_dp[d]    <= cs ? i_dp[d] : sh_dp[d];
          act_blank[d] <= cs ? i_blank[d] : sh_blank[d];
        end
        if (cs) begin
          sh_nib[d]   <= int'(i_data[4*d +: 4]);
          sh_dp[d]    <= i_dp[d];
          sh_blank[d] <= i_blank[d];
        end
      end
      pos <= (pos + 1) % FRAME;
    end
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    check8("cyc_sel", o_sel, exp_sel);
    check8("cyc_seg", o_seg, exp_seg);
    check8("cyc_frame", {7'b0, o_frame}, {7'b0, exp_frame});
  end

  // ---------------- directed helpers ----------------
  typedef struct {
    string       name;
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic        lzb;
    int          slot;
    logic [7:0]  e_sel;
    logic [7:0]  e_seg;
  } vec_t;

  task automatic wait_frame();
    int n;
    n = 0;
    while (!o_frame && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!o_frame) begin
      errors++;
      $display("FAIL frame_timeout: got no o_frame within %0d cycles, required a pulse", n);
    end
  endtask

  task automatic write_regs(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl);
    @(negedge clk);
    i_data = d; i_dp = dp; i_blank = bl; cs = 1'b1;
    @(negedge clk);
    cs = 1'b0;
  endtask

  vec_t vecs[10];
  int   cnt;

  initial begin
    vecs[0] = '{"dec_s0",   32'h1234ABCD, 8'h00, 8'h00, 1'b0, 0, 8'hFE, 8'hA1};
    vecs[1] = '{"dec_s7",   32'h1234ABCD, 8'h00, 8'h00, 1'b0, 7, 8'h7F, 8'hF9};
    vecs[2] = '{"blank_s3", 32'h1234ABCD, 8'h00, 8'h08, 1'b0, 3, 8'hFF, 8'hFF};
    vecs[3] = '{"blank_s4", 32'h1234ABCD, 8'h00, 8'h08, 1'b0, 4, 8'hEF, 8'h99};
    vecs[4] = '{"lzb_s0",   32'h00000042, 8'h00, 8'h00, 1'b1, 0, 8'hFE, 8'hA4};
    vecs[5] = '{"lzb_s1",   32'h00000042, 8'h00, 8'h00, 1'b1, 1, 8'hFD, 8'h99};
    vecs[6] = '{"lzb_s2",   32'h00000042, 8'h00, 8'h00, 1'b1, 2, 8'hFF, 8'hFF};
    vecs[7] = '{"lzb_s7",   32'h00000042, 8'h00, 8'h00, 1'b1, 7, 8'hFF, 8'hFF};
    vecs[8] = '{"lzb_zero", 32'h00000000, 8'h00, 8'h00, 1'b1, 0, 8'hFE, 8'hC0};
    vecs[9] = '{"dp_s0",    32'h00000000, 8'h01, 8'h00, 1'b0, 0, 8'hFE, 8'h40};

    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check8("first_sel", o_sel, 8'hFE);
    check8("first_seg", o_seg, 8'hC0);

    // Table vectors: load, wait for the frame that publishes it, sample slot at phase 0.
    for (int v = 0; v < 10; v++) begin
      i_lzb = vecs[v].lzb;
      write_regs(vecs[v].data, vecs[v].dp, vecs[v].blank);
      wait_frame();
      repeat (SLOT * vecs[v].slot + 1) @(negedge clk);
      check8({vecs[v].name, "_sel"}, o_sel, vecs[v].e_sel);
      check8({vecs[v].name, "_seg"}, o_seg, vecs[v].e_seg);
    end
    i_lzb = 1'b0;

    // Brightness: count lit cycles within slot 0.
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      i_bright = (b == 0) ? 4'd3 : 4'd0;
      wait_frame();
      cnt = 0;
      repeat (SLOT) begin
        @(negedge clk);
        if (o_sel != 8'hFF) cnt++;
      end
      check8("bright_cnt", 8'(cnt), 8'(int'(i_bright) + 1));
    end
    i_bright = 4'd15;

    // Frame pulse: one cycle wide, 128 cycles apart.
    wait_frame();
    @(negedge clk);
    check8("frame_width", {7'b0, o_frame}, 8'h00);
    cnt = 1;
    while (!o_frame && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    check8("frame_period", 8'(cnt), 8'd128);

    // Tear-free update: mid-frame write held until the wrap.
    write_regs(32'h11111111, 8'h00, 8'h00);
    wait_frame();
    repeat (32) @(negedge clk);
    write_regs(32'h22222222, 8'h00, 8'h00);
    repeat (48) @(negedge clk);
    check8("tear_hold", o_seg, 8'hF9);
    wait_frame();
    @(negedge clk);
    check8("tear_new", o_seg, 8'hA4);

    // Write on the wrap edge shows from slot 0 of the new frame.
    repeat (126) @(negedge clk);
    i_data = 32'h33333333; cs = 1'b1;
    @(negedge clk);
    cs = 1'b0;
    check8("sim_frame", {7'b0, o_frame}, 8'h01);
    check8("sim_old", o_seg, 8'hA4);
    @(negedge clk);
    check8("sim_new", o_seg, 8'hB0);

    // Reset mid-slot with pending shadow data.
    write_regs(32'h44444444, 8'h00, 8'h00);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check8("rst_seg", o_seg, 8'hFF);
    check8("rst_sel", o_sel, 8'hFF);
    check8("rst_frame", {7'b0, o_frame}, 8'h00);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check8("rst_first_sel", o_sel, 8'hFE);
    check8("rst_first_seg", o_seg, 8'hC0);
    wait_frame();
    @(negedge clk);
    check8("rst_discard", o_seg, 8'hC0);

    // Randomised traffic checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      cs = ($urandom_range(0, 15) == 0);
      if (cs) begin
        i_data  = $urandom >> $urandom_range(0, 31);
        i_dp    = 8'($urandom);
        i_blank = 8'($urandom & $urandom & $urandom);
      end
      if ($urandom_range(0, 63) == 0) i_lzb = ~i_lzb;
      if ($urandom_range(0, 63) == 0) i_bright = 4'($urandom);
    end
    @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
